// File: rtl/reg_file_2rp2wp.sv
// Dual-read, dual-write register file with optional write-to-read bypass,
// optional registered read and a sequential clear-all sweep.
module reg_file_2rp2wp #(
  parameter  int DATA_W   = 16,
  parameter  int DEPTH    = 4,
  parameter  int READ_REG = 0,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wen0_in,
  input  logic [AW-1:0]     waddr0_in,
  input  logic [DATA_W-1:0] wdata0_in,
  input  logic              wen1_in,
  input  logic [AW-1:0]     waddr1_in,
  input  logic [DATA_W-1:0] wdata1_in,
  input  logic [AW-1:0]     raddr0_in,
  output logic [DATA_W-1:0] rdata0_out,
  input  logic [AW-1:0]     raddr1_in,
  output logic [DATA_W-1:0] rdata1_out,
  input  logic              clr_in,
  output logic              busy_out
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_next0;
  logic [DATA_W-1:0] rd_next1;
  logic              byp_en;

  // NOTE: the storage array is reset entry by entry because reset must clear
  // the contents; this forces flops rather than a RAM macro, which is intended.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // NOTE: non-blocking updates resolve in program order, so port 1,
          // written last, wins a same-address collision.
          if (wen0_in) mem[waddr0_in] <= wdata0_in;
          if (wen1_in) mem[waddr1_in] <= wdata1_in;
          if (clr_in) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          cnt      <= cnt + AW'(1);
          if (cnt == AW'(DEPTH - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_out = (state == CLEAR);

  // Writes are dropped during the sweep, so forwarding them would lie.
  assign byp_en = (BYPASS != 0) && (state == IDLE);

  // NOTE: each output gets a default before the conditional overrides so no
  // latch is inferred.
  always_comb begin
    rd_next0 = mem[raddr0_in];
    rd_next1 = mem[raddr1_in];
    if (byp_en && wen0_in && (waddr0_in == raddr0_in)) rd_next0 = wdata0_in;
    if (byp_en && wen1_in && (waddr1_in == raddr0_in)) rd_next0 = wdata1_in;
    if (byp_en && wen0_in && (waddr0_in == raddr1_in)) rd_next1 = wdata0_in;
    if (byp_en && wen1_in && (waddr1_in == raddr1_in)) rd_next1 = wdata1_in;
  end

  generate
    if (READ_REG != 0) begin : g_reg_read
      always_ff @(posedge clock) begin
        if (reset) begin
          rdata0_out <= '0;
          rdata1_out <= '0;
        end else begin
          rdata0_out <= rd_next0;
          rdata1_out <= rd_next1;
        end
      end
    end else begin : g_comb_read
      assign rdata0_out = rd_next0;
      assign rdata1_out = rd_next1;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_2rp2wp.sv
// Directed bench: a combinational/bypass instance and a registered/no-bypass
// instance share one stimulus stream; expected values are hand-computed.
module tb_reg_file_2rp2wp;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              wen0 = 1'b0, wen1 = 1'b0, clr = 1'b0;
  logic [AW-1:0]     waddr0 = '0, waddr1 = '0, raddr0 = '0, raddr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic [DATA_W-1:0] rdata0, rdata1, rdata0_r, rdata1_r;
  logic              busy, busy_r;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  reg_file_2rp2wp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .READ_REG(0), .BYPASS(1)) u_dut (
    .clock(clock), .reset(reset),
    .wen0_in(wen0), .waddr0_in(waddr0), .wdata0_in(wdata0),
    .wen1_in(wen1), .waddr1_in(waddr1), .wdata1_in(wdata1),
    .raddr0_in(raddr0), .rdata0_out(rdata0),
    .raddr1_in(raddr1), .rdata1_out(rdata1),
    .clr_in(clr), .busy_out(busy)
  );

  reg_file_2rp2wp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .READ_REG(1), .BYPASS(0)) u_reg (
    .clock(clock), .reset(reset),
    .wen0_in(wen0), .waddr0_in(waddr0), .wdata0_in(wdata0),
    .wen1_in(wen1), .waddr1_in(waddr1), .wdata1_in(wdata1),
    .raddr0_in(raddr0), .rdata0_out(rdata0_r),
    .raddr1_in(raddr1), .rdata1_out(rdata1_r),
    .clr_in(clr), .busy_out(busy_r)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); failures++; end checks++;
    if (busy_r !== 1'b0) begin $display("FAIL reset_busy_r: got %b want 0", busy_r); failures++; end checks++;
    for (int a = 0; a < DEPTH; a++) begin
      raddr0 = AW'(a);
      raddr1 = AW'(DEPTH - 1 - a);
      #1;
      if (rdata0 !== 16'h0) begin $display("FAIL reset_rd0 a=%0d: got %h want 0000", a, rdata0); failures++; end checks++;
      if (rdata1 !== 16'h0) begin $display("FAIL reset_rd1 a=%0d: got %h want 0000", a, rdata1); failures++; end checks++;
      step();
      if (rdata0_r !== 16'h0) begin $display("FAIL reset_rd0_r a=%0d: got %h want 0000", a, rdata0_r); failures++; end checks++;
      if (rdata1_r !== 16'h0) begin $display("FAIL reset_rd1_r a=%0d: got %h want 0000", a, rdata1_r); failures++; end checks++;
    end
  endtask

  task automatic test_write_read();
    wen0 = 1'b1; waddr0 = 2'd2; wdata0 = 16'hA5A5;
    raddr1 = 2'd2;
    #1;
    if (rdata1 !== 16'hA5A5) begin $display("FAIL wr_bypass: got %h want a5a5", rdata1); failures++; end checks++;
    step();
    wen0 = 1'b0;
    #1;
    if (rdata1 !== 16'hA5A5) begin $display("FAIL wr_rd_comb: got %h want a5a5", rdata1); failures++; end checks++;
    if (rdata1_r !== 16'h0000) begin $display("FAIL wr_rd_reg_old: got %h want 0000", rdata1_r); failures++; end checks++;
    step();
    if (rdata1_r !== 16'hA5A5) begin $display("FAIL wr_rd_reg: got %h want a5a5", rdata1_r); failures++; end checks++;
  endtask

  task automatic test_same_addr();
    wen0 = 1'b1; waddr0 = 2'd1; wdata0 = 16'h7777;
    step();
    wen0 = 1'b1; waddr0 = 2'd1; wdata0 = 16'h1111;
    wen1 = 1'b1; waddr1 = 2'd1; wdata1 = 16'h2222;
    raddr0 = 2'd1;
    #1;
    if (rdata0 !== 16'h2222) begin $display("FAIL same_bypass_prio: got %h want 2222", rdata0); failures++; end checks++;
    step();
    wen0 = 1'b0; wen1 = 1'b0;
    #1;
    if (rdata0 !== 16'h2222) begin $display("FAIL same_commit: got %h want 2222", rdata0); failures++; end checks++;
    if (rdata0_r !== 16'h7777) begin $display("FAIL same_nobypass_old: got %h want 7777", rdata0_r); failures++; end checks++;
    step();
    if (rdata0_r !== 16'h2222) begin $display("FAIL same_reg_commit: got %h want 2222", rdata0_r); failures++; end checks++;
  endtask

  task automatic test_clear();
    wen0 = 1'b1; waddr0 = 2'd0; wdata0 = 16'd1;
    wen1 = 1'b1; waddr1 = 2'd1; wdata1 = 16'd2;
    step();
    waddr0 = 2'd2; wdata0 = 16'd3;
    waddr1 = 2'd3; wdata1 = 16'd4;
    step();
    wen0 = 1'b0; wen1 = 1'b0;
    raddr0 = 2'd0; raddr1 = 2'd1;
    #1;
    if (rdata0 !== 16'd1 || rdata1 !== 16'd2) begin
      $display("FAIL fill_01: got %h/%h want 0001/0002", rdata0, rdata1); failures++;
    end checks++;
    raddr0 = 2'd2; raddr1 = 2'd3;
    #1;
    if (rdata0 !== 16'd3 || rdata1 !== 16'd4) begin
      $display("FAIL fill_23: got %h/%h want 0003/0004", rdata0, rdata1); failures++;
    end checks++;

    clr = 1'b1;
    step();
    clr = 1'b0;
    // First sweep cycle: a write to addr 3 must neither bypass nor commit.
    wen0 = 1'b1; waddr0 = 2'd3; wdata0 = 16'hFFFF;
    raddr0 = 2'd3; raddr1 = 2'd0;
    #1;
    if (busy !== 1'b1 || busy_r !== 1'b1) begin $display("FAIL clr_busy_c1: got %b/%b want 1/1", busy, busy_r); failures++; end checks++;
    if (rdata0 !== 16'd4) begin $display("FAIL clr_no_bypass: got %h want 0004", rdata0); failures++; end checks++;
    if (rdata1 !== 16'd1) begin $display("FAIL clr_unswept0: got %h want 0001", rdata1); failures++; end checks++;
    step();
    wen0 = 1'b0;
    #1;
    if (busy !== 1'b1) begin $display("FAIL clr_busy_c2: got %b want 1", busy); failures++; end checks++;
    if (rdata0 !== 16'd4) begin $display("FAIL clr_write_dropped: got %h want 0004", rdata0); failures++; end checks++;
    if (rdata1 !== 16'd0) begin $display("FAIL clr_swept0: got %h want 0000", rdata1); failures++; end checks++;
    step();
    if (busy !== 1'b1) begin $display("FAIL clr_busy_c3: got %b want 1", busy); failures++; end checks++;
    step();
    if (busy !== 1'b1) begin $display("FAIL clr_busy_c4: got %b want 1", busy); failures++; end checks++;
    step();
    if (busy !== 1'b0 || busy_r !== 1'b0) begin $display("FAIL clr_busy_end: got %b/%b want 0/0", busy, busy_r); failures++; end checks++;
    for (int a = 0; a < DEPTH; a++) begin
      raddr0 = AW'(a);
      raddr1 = AW'(a);
      #1;
      if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin
        $display("FAIL clr_after a=%0d: got %h/%h want 0000/0000", a, rdata0, rdata1); failures++;
      end checks++;
    end
  endtask

  task automatic test_reset_during_clear();
    wen0 = 1'b1; waddr0 = 2'd2; wdata0 = 16'h9999;
    step();
    wen0 = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    if (busy !== 1'b1) begin $display("FAIL rst_clr_busy_pre: got %b want 1", busy); failures++; end checks++;
    reset = 1'b1;
    wen0 = 1'b1; waddr0 = 2'd2; wdata0 = 16'h5555;
    step();
    reset = 1'b0;
    wen0 = 1'b0;
    #1;
    if (busy !== 1'b0 || busy_r !== 1'b0) begin $display("FAIL rst_clr_busy: got %b/%b want 0/0", busy, busy_r); failures++; end checks++;
    if (rdata0_r !== 16'h0 || rdata1_r !== 16'h0) begin
      $display("FAIL rst_clr_rdreg: got %h/%h want 0000/0000", rdata0_r, rdata1_r); failures++;
    end checks++;
    for (int a = 0; a < DEPTH; a++) begin
      raddr0 = AW'(a);
      raddr1 = AW'(a);
      #1;
      if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin
        $display("FAIL rst_clr_entry a=%0d: got %h/%h want 0000/0000", a, rdata0, rdata1); failures++;
      end checks++;
    end
    // Back in IDLE: a write must commit again.
    wen1 = 1'b1; waddr1 = 2'd1; wdata1 = 16'h4242;
    step();
    wen1 = 1'b0;
    raddr0 = 2'd1;
    #1;
    if (rdata0 !== 16'h4242) begin $display("FAIL rst_clr_idle_write: got %h want 4242", rdata0); failures++; end checks++;
  endtask

  task automatic test_dual_write();
    wen0 = 1'b1; waddr0 = 2'd0; wdata0 = 16'h00FF;
    wen1 = 1'b1; waddr1 = 2'd3; wdata1 = 16'hFF00;
    raddr0 = 2'd0; raddr1 = 2'd3;
    #1;
    if (rdata0 !== 16'h00FF || rdata1 !== 16'hFF00) begin
      $display("FAIL dual_bypass: got %h/%h want 00ff/ff00", rdata0, rdata1); failures++;
    end checks++;
    step();
    wen0 = 1'b0; wen1 = 1'b0;
    #1;
    if (rdata0 !== 16'h00FF || rdata1 !== 16'hFF00) begin
      $display("FAIL dual_comb: got %h/%h want 00ff/ff00", rdata0, rdata1); failures++;
    end checks++;
    if (rdata0_r !== 16'h0 || rdata1_r !== 16'h0) begin
      $display("FAIL dual_reg_old: got %h/%h want 0000/0000", rdata0_r, rdata1_r); failures++;
    end checks++;
    step();
    if (rdata0_r !== 16'h00FF || rdata1_r !== 16'hFF00) begin
      $display("FAIL dual_reg: got %h/%h want 00ff/ff00", rdata0_r, rdata1_r); failures++;
    end checks++;
    raddr1 = 2'd0;
    #1;
    if (rdata1 !== rdata0 || rdata1 !== 16'h00FF) begin
      $display("FAIL dual_same_addr: got %h/%h want 00ff/00ff", rdata0, rdata1); failures++;
    end checks++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_addr();
    test_clear();
    test_reset_during_clear();
    test_dual_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
